bram_das_beamformer: RTL and testbench

//  Multi-channel delay-and-sum beamformer that reads per-channel sample memories (BRAMs,
//  1-cycle read latency) at channel-specific delayed addresses and emits one signed sum
//  per output index. It generalises the single-channel BRAM-fed beamformer to NUM_CH

---
 rtl/bram_das_beamformer_if.sv | 42 ++++
 rtl/bram_das_beamformer.sv | 143 ++++++++++++++
 tb/tb_bram_das_beamformer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_das_beamformer_if.sv
// Purpose: bundles the run-control, BRAM read and output-stream signals of
//          the delay-and-sum beamformer into one interface.
// Ports (signals):
//   start, abort      run request / run cancel
//   delays_in         per-channel delays, channel c at [c*DELAY_W +: DELAY_W]
//   rd_en, rd_addr    per-channel BRAM read enable / address
//   rd_data           per-channel BRAM q, valid one cycle after rd_en
//   out_value         signed sum of all channels
//   out_index         output sample index of out_value
//   out_valid         out_value/out_index valid this cycle
//   busy, done        run in progress / one-cycle completion pulse
// Modports: master = beamformer side, slave = controller/BRAM side.
interface bram_das_beamformer_if #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 11,
  parameter int DELAY_W  = 8
);
  localparam int OUT_W = SAMPLE_W + $clog2(NUM_CH);

  logic                         start;
  logic                         abort;
  logic [NUM_CH*DELAY_W-1:0]    delays_in;
  logic [NUM_CH-1:0]            rd_en;
  logic [NUM_CH*ADDR_W-1:0]     rd_addr;
  logic [NUM_CH*SAMPLE_W-1:0]   rd_data;
  logic signed [OUT_W-1:0]      out_value;
  logic [ADDR_W-1:0]            out_index;
  logic                         out_valid;
  logic                         busy;
  logic                         done;

  modport master (
    input  start, abort, delays_in, rd_data,
    output rd_en, rd_addr, out_value, out_index, out_valid, busy, done
  );

  modport slave (
    output start, abort, delays_in, rd_data,
    input  rd_en, rd_addr, out_value, out_index, out_valid, busy, done
  );
endinterface

// File: rtl/bram_das_beamformer.sv
// Purpose: multi-channel delay-and-sum beamformer. Each run walks output
//          index i = 0..NUM_SAMPLES-1, reads channel c at address i - delay_c
//          (or contributes zero while i < delay_c), and emits the signed
//          full-precision sum two cycles after the addresses are issued.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    bram_das_beamformer_if.master (control, BRAM reads, output stream)
module bram_das_beamformer #(
  parameter int NUM_CH      = 4,
  parameter int SAMPLE_W    = 16,
  parameter int ADDR_W      = 11,
  parameter int NUM_SAMPLES = 2048,
  parameter int DELAY_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bram_das_beamformer_if.master  bus
);
  localparam int OUT_W = SAMPLE_W + $clog2(NUM_CH);
  localparam int CMP_W = (ADDR_W > DELAY_W) ? ADDR_W : DELAY_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                      state;
  logic [ADDR_W-1:0]           idx;
  logic                        drain_cnt;
  logic [DELAY_W-1:0]          delay_q [NUM_CH];
  logic [NUM_CH-1:0]           s1_en;
  logic                        s1_valid;
  logic [ADDR_W-1:0]           s1_idx;

  logic [ADDR_W-1:0]           next_i;
  logic [DELAY_W-1:0]          cur_delay [NUM_CH];
  logic [NUM_CH-1:0]           next_en;
  logic [NUM_CH*ADDR_W-1:0]    next_addr;
  logic signed [OUT_W-1:0]     sum;

  // Addresses for the index about to be issued. On the start edge the delays
  // come straight from delays_in, since they are being latched that same edge.
  always_comb begin
    next_i    = (state == IDLE) ? '0 : ADDR_W'(idx + 1'b1);
    next_en   = '0;
    next_addr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      cur_delay[c] = (state == IDLE) ? bus.delays_in[c*DELAY_W +: DELAY_W] : delay_q[c];
      if (CMP_W'(next_i) >= CMP_W'(cur_delay[c])) begin
        next_en[c]                   = 1'b1;
        next_addr[c*ADDR_W +: ADDR_W] = ADDR_W'(CMP_W'(next_i) - CMP_W'(cur_delay[c]));
      end
    end
  end

  // rd_data is the BRAM q for the addresses issued last cycle; channels that
  // were not read are masked to zero so stale q values never leak in.
  always_comb begin
    sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (s1_en[c]) begin
        sum = sum + OUT_W'($signed(bus.rd_data[c*SAMPLE_W +: SAMPLE_W]));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      drain_cnt     <= 1'b0;
      s1_en         <= '0;
      s1_valid      <= 1'b0;
      s1_idx        <= '0;
      bus.rd_en     <= '0;
      bus.rd_addr   <= '0;
      bus.out_value <= '0;
      bus.out_index <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) delay_q[c] <= '0;
    end else begin
      bus.done      <= 1'b0;
      s1_en         <= bus.rd_en;
      s1_valid      <= (state == RUN);
      s1_idx        <= idx;
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_value <= sum;
        bus.out_index <= s1_idx;
      end

      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state       <= RUN;
            bus.busy    <= 1'b1;
            idx         <= '0;
            bus.rd_en   <= next_en;
            bus.rd_addr <= next_addr;
            for (int c = 0; c < NUM_CH; c++) begin
              delay_q[c] <= bus.delays_in[c*DELAY_W +: DELAY_W];
            end
          end
        end
        RUN, DRAIN: begin
          if (bus.abort) begin
            // Flush everything in flight; the run ends silently without done.
            state         <= IDLE;
            idx           <= '0;
            bus.busy      <= 1'b0;
            bus.rd_en     <= '0;
            bus.rd_addr   <= '0;
            s1_en         <= '0;
            s1_valid      <= 1'b0;
            bus.out_valid <= 1'b0;
          end else if (state == RUN) begin
            if (idx == LAST_IDX) begin
              state       <= DRAIN;
              drain_cnt   <= 1'b0;
              bus.rd_en   <= '0;
              bus.rd_addr <= '0;
            end else begin
              idx         <= next_i;
              bus.rd_en   <= next_en;
              bus.rd_addr <= next_addr;
            end
          end else begin
            // Two drain cycles let the last index clear both pipeline stages.
            if (drain_cnt) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end else begin
              drain_cnt <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bram_das_beamformer.sv
// Purpose: self-checking bench for bram_das_beamformer with a 1-cycle-latency
//          BRAM model per channel and directed runs with hand-computed values.
module tb_bram_das_beamformer;
  localparam int NUM_CH      = 4;
  localparam int SAMPLE_W    = 16;
  localparam int ADDR_W      = 11;
  localparam int NUM_SAMPLES = 128;
  localparam int DELAY_W     = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bram_das_beamformer_if #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W), .DELAY_W(DELAY_W)
  ) bus ();

  bram_das_beamformer #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W),
    .NUM_SAMPLES(NUM_SAMPLES), .DELAY_W(DELAY_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int     errors = 0;
  int     checks = 0;
  int     mode = 0;
  int     tb_delay [NUM_CH];
  int     out_count = 0;
  int     done_count = 0;
  int     ch0_reads = 0;
  longint vals [NUM_SAMPLES];

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Sample pattern stored in every channel's memory for the current mode.
  function automatic longint pat(input int m, input int a);
    case (m)
      0:       return longint'(a);
      1:       return 1;
      2:       return -32768;
      default: return 32767;
    endcase
  endfunction

  function automatic longint model(input int n);
    longint s = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (n >= tb_delay[c]) s += pat(mode, n - tb_delay[c]);
    end
    return s;
  endfunction

  // BRAM model: q registered one cycle after a read-enabled address.
  always @(posedge clk) begin
    if (!rst_n) begin
      bus.rd_data <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.rd_en[c]) begin
          bus.rd_data[c*SAMPLE_W +: SAMPLE_W] <=
            SAMPLE_W'(pat(mode, int'(bus.rd_addr[c*ADDR_W +: ADDR_W])));
        end
      end
    end
  end

  // Output monitor: every valid output is checked against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        checkOutput("out_index", longint'(bus.out_index), longint'(out_count % NUM_SAMPLES));
        checkOutput("out_value", longint'($signed(bus.out_value)), model(out_count % NUM_SAMPLES));
        if (bus.out_index < NUM_SAMPLES) vals[bus.out_index] = longint'($signed(bus.out_value));
        out_count++;
      end
      if (bus.done) done_count++;
      if (bus.rd_en[0]) ch0_reads++;
    end
  end

  // Starts one run; returns at the negedge of the first RUN cycle (index 0).
  task automatic applyStimulus(input int d0, input int d1, input int d2, input int d3, input int m);
    @(negedge clk);
    tb_delay[0] = d0; tb_delay[1] = d1; tb_delay[2] = d2; tb_delay[3] = d3;
    mode = m;
    out_count = 0; done_count = 0; ch0_reads = 0;
    for (int i = 0; i < NUM_SAMPLES; i++) vals[i] = -1;
    bus.delays_in = {DELAY_W'(d3), DELAY_W'(d2), DELAY_W'(d1), DELAY_W'(d0)};
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int exp_outputs);
    int got = 0;
    for (int k = 0; k < NUM_SAMPLES + 20; k++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1;
        break;
      end
    end
    checkOutput({tag, "_done_seen"}, got, 1);
    checkOutput({tag, "_busy_at_done"}, bus.busy, 0);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, bus.done, 0);
    @(negedge clk);
    checkOutput({tag, "_done_count"}, done_count, 1);
    checkOutput({tag, "_out_count"}, out_count, exp_outputs);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    int dones, cyc, first_done, gap;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.delays_in = '0;
    for (int c = 0; c < NUM_CH; c++) tb_delay[c] = 0;
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst_rd_en", bus.rd_en, 0);
    checkOutput("rst_rd_addr", bus.rd_addr, 0);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_value", bus.out_value, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: zero delays, x[n]=n -> 4n, latency 2 cycles
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t1_rd_en", bus.rd_en, 4'hF);
    checkOutput("t1_busy", bus.busy, 1);
    @(negedge clk);
    checkOutput("t1_valid_c1", bus.out_valid, 0);
    @(negedge clk);
    checkOutput("t1_valid_c2", bus.out_valid, 1);
    checkOutput("t1_index_c2", bus.out_index, 0);
    waitDone("t1", NUM_SAMPLES);
    checkOutput("t1_val5", vals[5], 20);
    checkOutput("t1_val127", vals[127], 508);
    checkOutput("t1_hold_index", bus.out_index, 127);

    // Test 2: staggered delays, constant ones
    applyStimulus(0, 1, 2, 3, 1);
    checkOutput("t2_rd_en_i0", bus.rd_en, 4'b0001);
    repeat (3) @(negedge clk);
    checkOutput("t2_rd_en_i3", bus.rd_en, 4'hF);
    checkOutput("t2_addr1_i3", bus.rd_addr[1*ADDR_W +: ADDR_W], 2);
    checkOutput("t2_addr2_i3", bus.rd_addr[2*ADDR_W +: ADDR_W], 1);
    checkOutput("t2_addr3_i3", bus.rd_addr[3*ADDR_W +: ADDR_W], 0);
    waitDone("t2", NUM_SAMPLES);
    checkOutput("t2_val0", vals[0], 1);
    checkOutput("t2_val1", vals[1], 2);
    checkOutput("t2_val2", vals[2], 3);
    checkOutput("t2_val3", vals[3], 4);
    checkOutput("t2_val4", vals[4], 4);

    // Test 3: signed extremes and a mixed-delay ramp
    applyStimulus(0, 0, 0, 0, 2);
    waitDone("t3n", NUM_SAMPLES);
    checkOutput("t3_min", vals[0], -131072);
    applyStimulus(0, 0, 0, 0, 3);
    waitDone("t3p", NUM_SAMPLES);
    checkOutput("t3_max", vals[10], 131068);
    applyStimulus(3, 0, 2, 1, 0);
    waitDone("t3m", NUM_SAMPLES);
    checkOutput("t3_mixed10", vals[10], 34);

    // Test 4: abort during the 100th RUN cycle
    applyStimulus(0, 0, 0, 0, 0);
    repeat (99) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checkOutput("t4_rd_en", bus.rd_en, 0);
    checkOutput("t4_out_valid", bus.out_valid, 0);
    checkOutput("t4_busy", bus.busy, 0);
    repeat (5) @(negedge clk);
    checkOutput("t4_done_count", done_count, 0);
    checkOutput("t4_out_count", out_count, 98);

    // Test 5: start held high -> back-to-back runs
    @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) tb_delay[c] = 0;
    mode = 0; out_count = 0; done_count = 0;
    bus.delays_in = '0;
    bus.start = 1'b1;
    dones = 0; cyc = 0; first_done = 0; gap = 0;
    for (int k = 0; k < 3 * NUM_SAMPLES + 20; k++) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        dones++;
        if (dones == 1) first_done = cyc;
        if (dones == 2) begin
          gap = cyc - first_done;
          bus.start = 1'b0;
          break;
        end
      end
    end
    bus.start = 1'b0;
    checkOutput("t5_dones", dones, 2);
    checkOutput("t5_gap", gap, NUM_SAMPLES + 3);
    repeat (2) @(negedge clk);
    checkOutput("t5_out_count", out_count, 2 * NUM_SAMPLES);
    checkOutput("t5_done_count", done_count, 2);
    checkOutput("t5_busy", bus.busy, 0);

    // Test 6: out-of-range delay on ch0, then async reset mid-DRAIN
    applyStimulus(255, 0, 0, 0, 0);
    repeat (NUM_SAMPLES) @(negedge clk);
    checkOutput("t6_busy_drain", bus.busy, 1);
    checkOutput("t6_rd_en_drain", bus.rd_en, 0);
    checkOutput("t6_ch0_reads", ch0_reads, 0);
    checkOutput("t6_val5", vals[5], 15);
    checkOutput("t6_val100", vals[100], 300);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_out_valid", bus.out_valid, 0);
    checkOutput("t6_rst_out_value", bus.out_value, 0);
    checkOutput("t6_rst_out_index", bus.out_index, 0);
    checkOutput("t6_rst_busy", bus.busy, 0);
    checkOutput("t6_rst_done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("t6_no_done", done_count, 0);
    checkOutput("t6_idle_busy", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
